wall_scheduler: RTL and testbench

WALL_SCHEDULER -- requirements
Module: wall_scheduler

---
 rtl/wall_scheduler_if.sv | 20 ++
 rtl/wall_scheduler.sv | 138 +++++++++++++
 tb/tb_wall_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/wall_scheduler_if.sv
// wall_scheduler_if -- bundle between the wall scheduler and the per-wall
// controllers.
//   wall_ready : controller -> scheduler, high = wall idle and spawnable
//   wall_done  : controller -> scheduler, one-cycle pulse when a wall leaves the screen
//   wall_go    : scheduler -> controller, one-hot one-cycle spawn pulse
//   busy_count : scheduler -> observer, number of wall_ready bits that are low
// Modports: master = scheduler side, slave = wall-controller side.
interface wall_scheduler_if #(
  parameter int NUM_WALLS = 4
);
  localparam int CW = $clog2(NUM_WALLS + 1);

  logic [NUM_WALLS-1:0] wall_ready;
  logic [NUM_WALLS-1:0] wall_done;
  logic [NUM_WALLS-1:0] wall_go;
  logic [CW-1:0]        busy_count;

  modport master (input wall_ready, wall_done, output wall_go, busy_count);
  modport slave  (output wall_ready, wall_done, input wall_go, busy_count);
endinterface

// File: rtl/wall_scheduler.sv
// wall_scheduler -- spawns walls on a fixed cadence, round-robin over the
// wall controllers, counts cleared walls and latches game over on a hit.
// Ports:
//   clk, resetn  : clock, synchronous active-low reset
//   enable       : game running; low returns to IDLE and pauses spawning
//   player_hit   : collision; in COUNT/ISSUE moves to OVER (left only by reset)
//   walls        : wall_scheduler_if.master (wall_ready, wall_done in;
//                  wall_go, busy_count out)
//   score        : cleared-wall count, saturates at 255, frozen in OVER
//   game_over    : high while in OVER
// Optional feature: define WALL_SPEEDUP_EN to shorten the spawn interval by
// SPEEDUP_STEP (floored at MIN_INTERVAL) on every 8th score increment.
// Without it the interval stays at SPAWN_INTERVAL.
module wall_scheduler #(
  parameter int NUM_WALLS      = 4,
  parameter int INTERVAL_W     = 26,
  parameter int SPAWN_INTERVAL = 50_000_000,
  parameter int MIN_INTERVAL   = 12_500_000,
  parameter int SPEEDUP_STEP   = 2_500_000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    player_hit,
  wall_scheduler_if.master        walls,
  output logic [7:0]              score,
  output logic                    game_over
);
  localparam int PW = $clog2(NUM_WALLS);
  localparam int CW = $clog2(NUM_WALLS + 1);
  localparam logic [INTERVAL_W-1:0] SPAWN_I = INTERVAL_W'(SPAWN_INTERVAL);

  typedef enum logic [1:0] {IDLE, COUNT, ISSUE, OVER} state_t;

  state_t                  state, state_nxt;
  logic [INTERVAL_W-1:0]   cnt, cnt_nxt, cur_interval;
  logic [PW-1:0]           ptr, ptr_nxt, sel;
  logic                    found;
  logic [NUM_WALLS-1:0]    go;
  logic [7:0]              score_nxt;
  logic                    score_inc;

  // Round-robin scan: first ready wall at or after ptr, wrapping.
  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NUM_WALLS; i++) begin
      idx  = (int'(ptr) + i) % NUM_WALLS;
      cand = PW'(idx);
      if (!found && walls.wall_ready[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    logic [CW-1:0] bc;
    bc = '0;
    for (int i = 0; i < NUM_WALLS; i++)
      bc = bc + CW'(!walls.wall_ready[i]);
    walls.busy_count = bc;
  end

  // Next-state; player_hit outranks enable and the spawn itself.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    go        = '0;
    case (state)
      IDLE: if (enable) begin
        state_nxt = COUNT;
        cnt_nxt   = cur_interval - 1'b1;
      end
      COUNT: begin
        if (player_hit)     state_nxt = OVER;
        else if (!enable)   state_nxt = IDLE;
        else if (cnt == '0) state_nxt = ISSUE;
        else                cnt_nxt   = cnt - 1'b1;
      end
      ISSUE: begin
        if (player_hit)   state_nxt = OVER;
        else if (!enable) state_nxt = IDLE;
        else if (found) begin
          go        = NUM_WALLS'(1) << sel;
          ptr_nxt   = (sel == PW'(NUM_WALLS - 1)) ? '0 : sel + 1'b1;
          cnt_nxt   = cur_interval - 1'b1;
          state_nxt = COUNT;
        end
      end
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by resetn so a reset cycle never leaks a spawn pulse.
  assign walls.wall_go = resetn ? go : '0;
  assign game_over     = (state == OVER);

  assign score_nxt = score + 8'd1;
  assign score_inc = (state != OVER) && (|walls.wall_done) && (score != 8'hFF);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      score <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      if (score_inc) score <= score_nxt;
    end
  end

`ifdef WALL_SPEEDUP_EN
  localparam logic [INTERVAL_W:0] MIN_I  = (INTERVAL_W+1)'(MIN_INTERVAL);
  localparam logic [INTERVAL_W:0] STEP_I = (INTERVAL_W+1)'(SPEEDUP_STEP);

  // Compared one bit wider so MIN+STEP cannot wrap; applies from the next load.
  always_ff @(posedge clk) begin
    if (!resetn)
      cur_interval <= SPAWN_I;
    else if (score_inc && score_nxt[2:0] == 3'b000)
      cur_interval <= ({1'b0, cur_interval} >= MIN_I + STEP_I)
                      ? INTERVAL_W'({1'b0, cur_interval} - STEP_I)
                      : INTERVAL_W'(MIN_I);
  end
`else
  assign cur_interval = SPAWN_I;
`endif
endmodule

// File: tb/tb_wall_scheduler.sv
module tb_wall_scheduler;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       player_hit = 1'b0;
  logic [7:0] score;
  logic       game_over;
  int         checks = 0;
  int         failures = 0;

  wall_scheduler_if #(.NUM_WALLS(4)) wif ();

  wall_scheduler #(
    .NUM_WALLS(4), .INTERVAL_W(8), .SPAWN_INTERVAL(4),
    .MIN_INTERVAL(2), .SPEEDUP_STEP(1)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .player_hit(player_hit),
    .walls(wif), .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] rdy;
    logic [3:0] done;
    logic       hit;
    logic [3:0] go;
    logic       over;
    logic [2:0] busy;
    logic       cs;
    logic [7:0] score;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic en, logic [3:0] rdy, logic [3:0] done,
                              logic hit, logic [3:0] go, logic over,
                              logic [2:0] busy, logic cs, logic [7:0] sc);
    vec_t v;
    v.en = en; v.rdy = rdy; v.done = done; v.hit = hit; v.go = go;
    v.over = over; v.busy = busy; v.cs = cs; v.score = sc;
    return v;
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Inputs are applied just after an edge; outputs sampled at the falling edge.
  task automatic apply(input vec_t v, input string tag, input int cyc);
    enable = v.en; wif.wall_ready = v.rdy; wif.wall_done = v.done;
    player_hit = v.hit;
    @(negedge clk);
    chk({tag, "_go"},   cyc, 32'(wif.wall_go),    32'(v.go));
    chk({tag, "_over"}, cyc, 32'(game_over),      32'(v.over));
    chk({tag, "_busy"}, cyc, 32'(wif.busy_count), 32'(v.busy));
    if (v.cs) chk({tag, "_score"}, cyc, 32'(score), 32'(v.score));
    @(posedge clk); #1;
  endtask

  // Hostile inputs during reset: nothing may spawn or count.
  task automatic do_reset();
    resetn = 1'b0; enable = 1'b1; player_hit = 1'b1;
    wif.wall_ready = 4'hF; wif.wall_done = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_go",    0, 32'(wif.wall_go), 32'h0);
    chk("rst_over",  0, 32'(game_over),   32'h0);
    chk("rst_score", 0, 32'(score),       32'h0);
    @(posedge clk); #1;
    resetn = 1'b1; enable = 1'b0; player_hit = 1'b0;
    wif.wall_ready = 4'h0; wif.wall_done = 4'h0;
  endtask

  // Enable from IDLE, return cycle of first pulse and gap to the second.
  task automatic measure(output int first, output int gap);
    int t1, t2;
    t1 = -1; t2 = -1;
    enable = 1'b1; wif.wall_ready = 4'hF; wif.wall_done = 4'h0; player_hit = 1'b0;
    for (int c = 0; c < 40 && t2 < 0; c++) begin
      @(negedge clk);
      if (wif.wall_go != 4'h0) begin
        if (t1 < 0) t1 = c; else t2 = c;
      end
      @(posedge clk); #1;
    end
    enable = 1'b0;
    @(posedge clk); #1;
    first = t1;
    gap   = (t2 < 0) ? -1 : t2 - t1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++)
      apply(mk(1'b0, 4'hF, 4'b0001, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 8'd0), "pls", i);
  endtask

  initial begin
    logic [3:0] one;
    int first, gap;
    int exp_sp[4];
    one = 4'b0001;

    // Basic cadence, all walls ready.
    do_reset();
    tv.delete();
    for (int c = 0; c <= 25; c++)
      tv.push_back(mk(1'b1, 4'hF, 4'h0, 1'b0,
                      (c > 0 && c % 5 == 0) ? one << ((c / 5 - 1) % 4) : 4'h0,
                      1'b0, 3'd0, 1'b1, 8'd0));
    foreach (tv[c]) apply(tv[c], "rr", c);

    // No wall ready at spawn time: wait, then fire the first cycle wall 2 is ready.
    do_reset();
    tv.delete();
    for (int c = 0; c <= 13; c++)
      tv.push_back(mk(1'b1, (c >= 8) ? 4'b0100 : 4'b0000, 4'h0, 1'b0,
                      (c == 8 || c == 13) ? 4'b0100 : 4'h0, 1'b0,
                      (c >= 8) ? 3'd3 : 3'd4, 1'b0, 8'd0));
    foreach (tv[c]) apply(tv[c], "stall", c);

    // Hit in the spawn cycle; OVER holds and freezes score; reset clears it.
    do_reset();
    for (int c = 0; c <= 4; c++)
      apply(mk(1'b1, 4'hF, (c == 2) ? 4'b0001 : 4'h0, 1'b0, 4'h0, 1'b0, 3'd0,
               1'b1, (c >= 3) ? 8'd1 : 8'd0), "hit", c);
    apply(mk(1'b1, 4'hF, 4'h0,    1'b1, 4'h0, 1'b0, 3'd0, 1'b1, 8'd1), "hit", 5);
    apply(mk(1'b1, 4'hF, 4'b0010, 1'b0, 4'h0, 1'b1, 3'd0, 1'b1, 8'd1), "hit", 6);
    apply(mk(1'b0, 4'hF, 4'b0001, 1'b0, 4'h0, 1'b1, 3'd0, 1'b1, 8'd1), "hit", 7);
    for (int c = 8; c <= 12; c++)
      apply(mk(1'b1, 4'hF, 4'b0011, 1'(c % 2), 4'h0, 1'b1, 3'd0, 1'b1, 8'd1), "hit", c);
    do_reset();
    apply(mk(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd4, 1'b1, 8'd0), "postrst", 0);

    // Score saturation; multi-bit done counts once.
    do_reset();
    for (int n = 0; n < 300; n++)
      apply(mk(1'b0, 4'b1010, (n % 3 == 0) ? 4'b0011 : 4'b0100, 1'b0, 4'h0, 1'b0,
               3'd2, 1'b1, (n < 255) ? 8'(n) : 8'd255), "sat", n);
    apply(mk(1'b0, 4'b1010, 4'h0, 1'b0, 4'h0, 1'b0, 3'd2, 1'b1, 8'd255), "sat", 300);

    // Spawn spacing versus score.
`ifdef WALL_SPEEDUP_EN
    exp_sp = '{5, 4, 3, 3};
`else
    exp_sp = '{5, 5, 5, 5};
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) pulses(8);
      measure(first, gap);
      chk("sp_first", k, 32'(first), 32'(exp_sp[k]));
      chk("sp_gap",   k, 32'(gap),   32'(exp_sp[k]));
    end
    pulses(8);
    measure(first, gap);
    chk("sp_gap32", 4, 32'(gap), 32'(exp_sp[3]));

    // Enable dropped mid-COUNT: no pulse, pointer kept across re-enable.
    do_reset();
    for (int c = 0; c <= 15; c++)
      apply(mk(!(c >= 7 && c <= 9), 4'hF, 4'h0, 1'b0,
               (c == 5) ? 4'b0001 : (c == 15) ? 4'b0010 : 4'h0,
               1'b0, 3'd0, 1'b0, 8'd0), "pause", c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
